// File: rtl/encoder_4x2_req_if.sv
// Request/handshake bundle between a request source and the 4x2 request encoder.
// D and pending are indexed [0:3] so that element i is request index i.
interface encoder_4x2_req_if;
  logic       enable;
  logic [0:3] D;
  logic       ack;
  logic       A;
  logic       B;
  logic       valid;
  logic [0:3] pending;
  logic       dropped;

  modport master (
    output enable, D, ack,
    input  A, B, valid, pending, dropped
  );

  modport slave (
    input  enable, D, ack,
    output A, B, valid, pending, dropped
  );
endinterface

// File: rtl/encoder_4x2_req.sv
// Sequential 4-to-2 priority encoder: latches rising request edges into pending bits,
// presents the highest pending index as (A,B) with valid, and holds it until acknowledged.
module encoder_4x2_req (
  input  logic                  clk,
  input  logic                  reset,
  encoder_4x2_req_if.slave      bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [0:3] d_prev_q;
  logic [0:3] pending_q, pending_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       valid_q, valid_d;
  logic       dropped_q, dropped_d;

  logic [0:3] rise_s;
  logic [0:3] cap_s;
  logic [0:3] clr_s;
  logic [1:0] code_s;
  logic [1:0] sel_s;

  function automatic logic [1:0] prio_sel(input logic [0:3] p);
    logic [1:0] r;
    if (p[3]) begin
      r = 2'd3;
    end else if (p[2]) begin
      r = 2'd2;
    end else if (p[1]) begin
      r = 2'd1;
    end else begin
      r = 2'd0;
    end
    return r;
  endfunction

  // Edge capture, ack clear (set wins on collision) and drop detection
  always_comb begin
    rise_s = bus.D & ~d_prev_q;
    cap_s  = bus.enable ? rise_s : 4'b0000;
    code_s = {a_q, b_q};
    clr_s  = 4'b0000;
    if ((state_q == ST_HOLD) && bus.ack) begin
      clr_s[code_s] = 1'b1;
    end else begin
      clr_s = 4'b0000;
    end
    pending_d = (pending_q & ~clr_s) | cap_s;
    dropped_d = |(cap_s & pending_q & ~clr_s);
    sel_s     = prio_sel(pending_q);
  end

  // Presentation FSM: IDLE picks the winner, HOLD waits for ack, GAP spaces pulses
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (bus.enable && (pending_q != 4'b0000)) begin
          {a_d, b_d} = sel_s;
          valid_d    = 1'b1;
          state_d    = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (bus.ack) begin
          valid_d = 1'b0;
          state_d = ST_GAP;
        end else begin
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_GAP: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset samples D so lines held high through reset are not new requests
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      d_prev_q  <= bus.D;
      pending_q <= 4'b0000;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      d_prev_q  <= bus.D;
      pending_q <= pending_d;
      a_q       <= a_d;
      b_q       <= b_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  assign bus.A       = a_q;
  assign bus.B       = b_q;
  assign bus.valid   = valid_q;
  assign bus.pending = pending_q;
  assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_encoder_4x2_req.sv
// Self-checking bench for encoder_4x2_req: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural request model.
module tb_encoder_4x2_req;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;
  bit   chk_on;

  encoder_4x2_req_if bus ();

  encoder_4x2_req dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [0:3] m_pend;
  logic [0:3] m_prev;
  logic [0:3] m_old;
  bit         m_valid;
  bit         m_gap;
  bit         m_drop;
  int         m_code;
  bit         rising;
  bit         cleared;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [0:3] dec2x4(input logic en, input logic a, input logic b);
    logic [0:3] y;
    y = 4'b0000;
    if (en) y[{a, b}] = 1'b1;
    return y;
  endfunction

  // Model: requests are a set of pending indices; a presentation is held until ack,
  // followed by one quiet cycle before the next winner may be chosen.
  always @(posedge clk) begin
    if (reset) begin
      m_pend  = 4'b0000;
      m_prev  = bus.D;
      m_valid = 1'b0;
      m_gap   = 1'b0;
      m_drop  = 1'b0;
      m_code  = 0;
    end else begin
      m_old  = m_pend;
      m_drop = 1'b0;
      for (int i = 0; i < 4; i++) begin
        rising  = bus.D[i] && !m_prev[i];
        cleared = m_valid && bus.ack && (m_code == i);
        if (bus.enable && rising) begin
          if (m_old[i] && !cleared) m_drop = 1'b1;
          m_pend[i] = 1'b1;
        end else if (cleared) begin
          m_pend[i] = 1'b0;
        end
      end
      if (m_valid) begin
        if (bus.ack) begin
          m_valid = 1'b0;
          m_gap   = 1'b1;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (bus.enable && (m_old != 4'b0000)) begin
        for (int i = 0; i < 4; i++) if (m_old[i]) m_code = i;
        m_valid = 1'b1;
      end
      m_prev = bus.D;
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_A",       {7'd0, bus.A},       {7'd0, m_code[1]});
      chk("model_B",       {7'd0, bus.B},       {7'd0, m_code[0]});
      chk("model_valid",   {7'd0, bus.valid},   {7'd0, m_valid});
      chk("model_pending", {4'd0, bus.pending}, {4'd0, m_pend});
      chk("model_dropped", {7'd0, bus.dropped}, {7'd0, m_drop});
    end
  end

  initial begin
    logic [0:3] oh;
    n_checks   = 0;
    n_fails    = 0;
    chk_on     = 1'b0;
    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.D      = 4'b0000;
    bus.ack    = 1'b0;
    tick(2);
    chk("rst_valid",   {7'd0, bus.valid},   8'd0);
    chk("rst_code",    {6'd0, bus.A, bus.B}, 8'd0);
    chk("rst_pending", {4'd0, bus.pending}, 8'd0);
    chk("rst_dropped", {7'd0, bus.dropped}, 8'd0);
    chk_on = 1'b1;
    reset  = 1'b0;
    tick(1);

    // Single request on index 2
    bus.D = 4'b0010;
    tick(1);
    chk("t1_pending", {4'd0, bus.pending}, {4'd0, 4'b0010});
    chk("t1_valid0",  {7'd0, bus.valid}, 8'd0);
    tick(1);
    chk("t1_code",    {6'd0, bus.A, bus.B}, 8'd2);
    chk("t1_valid",   {7'd0, bus.valid}, 8'd1);
    tick(5);
    chk("t1_hold",    {5'd0, bus.valid, bus.A, bus.B}, 8'h6);
    bus.ack = 1'b1;
    tick(1);
    bus.ack = 1'b0;
    chk("t1_gap",     {3'd0, bus.valid, bus.pending}, 8'h0);
    tick(2);
    chk("t1_idle",    {7'd0, bus.valid}, 8'd0);

    // Priority without preemption
    bus.D = 4'b0000;
    tick(1);
    bus.D = 4'b1100;
    tick(2);
    chk("t2_code01",  {5'd0, bus.valid, bus.A, bus.B}, 8'h5);
    bus.D = 4'b1101;
    tick(1);
    chk("t2_nopre",   {5'd0, bus.valid, bus.A, bus.B}, 8'h5);
    chk("t2_pend",    {4'd0, bus.pending}, {4'd0, 4'b1101});
    bus.ack = 1'b1;
    tick(1);
    bus.ack = 1'b0;
    chk("t2_clr1",    {4'd0, bus.pending}, {4'd0, 4'b1001});
    tick(2);
    chk("t2_code11",  {5'd0, bus.valid, bus.A, bus.B}, 8'h7);
    bus.ack = 1'b1;
    tick(1);
    bus.ack = 1'b0;
    tick(2);
    chk("t2_code00",  {5'd0, bus.valid, bus.A, bus.B}, 8'h4);
    chk("t2_pend0",   {4'd0, bus.pending}, {4'd0, 4'b1000});
    bus.ack = 1'b1;
    tick(1);
    bus.ack = 1'b0;
    bus.D   = 4'b0000;
    tick(2);

    // Drop pulse and set-wins on ack collision
    bus.D = 4'b0100;
    tick(2);
    chk("t3_code01",  {5'd0, bus.valid, bus.A, bus.B}, 8'h5);
    bus.D = 4'b0000;
    tick(1);
    bus.D = 4'b0100;
    tick(1);
    chk("t3_drop",    {7'd0, bus.dropped}, 8'd1);
    tick(1);
    chk("t3_drop_end", {7'd0, bus.dropped}, 8'd0);
    bus.D = 4'b0000;
    tick(1);
    bus.D   = 4'b0100;
    bus.ack = 1'b1;
    tick(1);
    bus.ack = 1'b0;
    chk("t3_setwins", {3'd0, bus.dropped, bus.pending}, {4'd0, 4'b0100});
    tick(2);
    chk("t3_repres",  {5'd0, bus.valid, bus.A, bus.B}, 8'h5);
    bus.ack = 1'b1;
    tick(1);
    bus.ack = 1'b0;
    bus.D   = 4'b0000;
    tick(2);

    // Enable gating
    bus.enable = 1'b0;
    bus.D      = 4'b0010;
    tick(1);
    chk("t4_gated",   {3'd0, bus.valid, bus.pending}, 8'h0);
    bus.enable = 1'b1;
    tick(2);
    chk("t4_noedge",  {3'd0, bus.valid, bus.pending}, 8'h0);
    bus.D = 4'b0000;
    tick(1);

    // Reset in the middle of a handshake
    bus.D = 4'b1010;
    tick(2);
    chk("t5_pre",     {bus.valid, bus.A, bus.B, 1'b0, bus.pending}, {4'b1100, 4'b1010});
    bus.D = 4'b1011;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t5_rst",     {2'd0, bus.dropped, bus.valid, bus.pending}, 8'h0);
    chk("t5_rstcode", {6'd0, bus.A, bus.B}, 8'd0);
    tick(2);
    chk("t5_nocap",   {3'd0, bus.valid, bus.pending}, 8'h0);
    bus.D = 4'b0000;
    tick(1);

    // Round trip through a 2x4 decoder
    for (int i = 0; i < 4; i++) begin
      oh    = 4'b0000;
      oh[i] = 1'b1;
      bus.D = oh;
      tick(2);
      chk("t6_roundtrip", {4'd0, dec2x4(bus.valid, bus.A, bus.B)}, {4'd0, oh});
      bus.ack = 1'b1;
      tick(1);
      bus.ack = 1'b0;
      bus.D   = 4'b0000;
      tick(2);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bus.D      = 4'($urandom);
      bus.enable = ($urandom_range(0, 7) != 0);
      bus.ack    = ($urandom_range(0, 2) == 0);
      reset      = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    reset   = 1'b0;
    bus.ack = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
